// File: rtl/fade_pkg.sv
// rtl/fade_pkg.sv - shared state type and helpers for the multi-channel LED fader
package fade_pkg;

  typedef enum logic [2:0] {
    DELAY,
    RISE,
    HOLD_ON,
    FALL,
    HOLD_OFF
  } fade_state_t;

  // Duty increment applied on every ramp tick
  function automatic int level_step(input int interval, input int steps);
    return interval / steps;
  endfunction

  // Largest of three values, used to size the per-channel tick counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// rtl/fade_channel.sv - one fader channel: ramp/hold FSM, duty level and PWM compare
module fade_channel
  import fade_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS        = 200,
  parameter int HOLD_STEPS   = 200,
  parameter int DELAY_STEPS  = 0,
  parameter int LEVEL_STEP   = 6,
  parameter int LW           = 11,
  parameter int SCW          = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [LW-1:0] pwm_cnt,
  output logic [LW-1:0] level,
  output logic          pwm_out,
  output logic          wrap_out
);

  localparam logic [LW-1:0]  STEP_L     = LW'(LEVEL_STEP);
  localparam logic [LW-1:0]  FULL_L     = LW'(PWM_INTERVAL);
  localparam logic [SCW-1:0] RAMP_LAST  = SCW'(STEPS - 1);
  localparam logic [SCW-1:0] HOLD_LAST  = SCW'(HOLD_STEPS - 1);
  localparam logic [SCW-1:0] DELAY_LAST = SCW'((DELAY_STEPS > 0) ? DELAY_STEPS - 1 : 0);
  localparam fade_state_t    START      = (DELAY_STEPS > 0) ? DELAY : RISE;

  fade_state_t    state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [LW-1:0]  level_d;
  logic           wrap_d;

  // Next state, tick count and level; nothing moves except on a tick
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    level_d = level;
    wrap_d  = 1'b0;
    if (tick) begin
      sc_d = sc_q + 1'b1;
      case (state_q)
        DELAY: begin
          if (sc_q == DELAY_LAST) begin
            state_d = RISE;
            sc_d    = '0;
          end
        end
        RISE: begin
          if (sc_q == RAMP_LAST) begin
            level_d = FULL_L;
            state_d = HOLD_ON;
            sc_d    = '0;
          end else begin
            level_d = level + STEP_L;
          end
        end
        HOLD_ON: begin
          if (sc_q == HOLD_LAST) begin
            state_d = FALL;
            sc_d    = '0;
          end
        end
        FALL: begin
          if (sc_q == RAMP_LAST) begin
            level_d = '0;
            state_d = HOLD_OFF;
            sc_d    = '0;
          end else begin
            level_d = level - STEP_L;
          end
        end
        HOLD_OFF: begin
          if (sc_q == HOLD_LAST) begin
            state_d = RISE;
            sc_d    = '0;
            wrap_d  = 1'b1;
          end
        end
        default: begin
          state_d = START;
          sc_d    = '0;
        end
      endcase
    end
  end

  // State registers plus the registered duty compare against the shared PWM counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= START;
      sc_q     <= '0;
      level    <= '0;
      pwm_out  <= 1'b0;
      wrap_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      level    <= level_d;
      pwm_out  <= (pwm_cnt < level);
      wrap_out <= wrap_d;
    end
  end

endmodule

// File: rtl/fade_multi.sv
// rtl/fade_multi.sv - staggered multi-channel LED fader with shared prescaler and PWM counter
module fade_multi
  import fade_pkg::*;
#(
  parameter int   NUM_CH        = 3,
  parameter int   PWM_INTERVAL  = 1200,
  parameter int   STEP_INTERVAL = 12000,
  parameter int   STEPS         = 200,
  parameter int   HOLD_STEPS    = 200,
  parameter int   PHASE_STEPS   = 133,
  localparam int  LW            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [NUM_CH*LW-1:0] level,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 wrap
);

  localparam int LEVEL_STEP = level_step(PWM_INTERVAL, STEPS);
  localparam int SCW = $clog2(max3(STEPS, HOLD_STEPS, (NUM_CH - 1) * PHASE_STEPS) + 1);
  localparam int PW  = $clog2(STEP_INTERVAL + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_INTERVAL - 1);
  localparam logic [LW-1:0] PWM_LAST   = LW'(PWM_INTERVAL - 1);

  logic [PW-1:0]     presc;
  logic [LW-1:0]     pwm_cnt;
  logic              tick;
  logic [NUM_CH-1:0] wrap_vec;
  logic              unused_wrap;

  assign tick = en && (presc == PRESC_LAST);

  // Step prescaler; freezes with en low so no tick is lost or duplicated
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Free-running PWM period counter shared by all channels
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fade_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .STEPS        (STEPS),
      .HOLD_STEPS   (HOLD_STEPS),
      .DELAY_STEPS  (i * PHASE_STEPS),
      .LEVEL_STEP   (LEVEL_STEP),
      .LW           (LW),
      .SCW          (SCW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .level    (level[i*LW +: LW]),
      .pwm_out  (pwm_out[i]),
      .wrap_out (wrap_vec[i])
    );
  end

  // Only channel 0 marks the cycle boundary
  assign wrap        = wrap_vec[0];
  assign unused_wrap = ^wrap_vec;

endmodule

// File: tb/tb_fade_multi.sv
// tb/tb_fade_multi.sv - directed self-checking bench for fade_multi
module tb_fade_multi;

  localparam int NUM_CH        = 2;
  localparam int PWM_INTERVAL  = 8;
  localparam int STEP_INTERVAL = 4;
  localparam int STEPS         = 4;
  localparam int HOLD_STEPS    = 2;
  localparam int PHASE_STEPS   = 3;
  localparam int LW            = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NUM_CH*LW-1:0] level;
  logic [NUM_CH-1:0]    pwm_out;
  logic                 wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fade_multi #(
    .NUM_CH        (NUM_CH),
    .PWM_INTERVAL  (PWM_INTERVAL),
    .STEP_INTERVAL (STEP_INTERVAL),
    .STEPS         (STEPS),
    .HOLD_STEPS    (HOLD_STEPS),
    .PHASE_STEPS   (PHASE_STEPS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .level   (level),
    .pwm_out (pwm_out),
    .wrap    (wrap)
  );

  // Hand-written 12-tick profile: level after a channel has seen 'ticks' ticks
  function automatic int exp_lvl(input int ticks, input int dly);
    int k;
    if (ticks <= dly) return 0;
    k = (ticks - dly - 1) % 12;
    case (k)
      0: return 2;   1: return 4;   2: return 6;   3: return 8;
      4: return 8;   5: return 8;   6: return 6;   7: return 4;
      8: return 2;   9: return 0;   10: return 0;  default: return 0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL reset_level got %h want 0", level);
    end
    checks++;
    if (pwm_out !== '0) begin
      errors++;
      $display("FAIL reset_pwm got %b want 0", pwm_out);
    end
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap got %b want 0", wrap);
    end
  endtask

  task automatic test_ramp();
    int e0, e1;
    logic [1:0] ep;
    logic ew;
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      @(negedge clk);
      e0    = exp_lvl(c / 4, 0);
      e1    = exp_lvl(c / 4, 3);
      ep[0] = ((c - 1) % 8) < exp_lvl((c - 1) / 4, 0);
      ep[1] = ((c - 1) % 8) < exp_lvl((c - 1) / 4, 3);
      ew    = (c % 48 == 0);
      checks++;
      if (level[3:0] !== e0[3:0]) begin
        errors++;
        $display("FAIL ramp_lvl0 c=%0d got %0d want %0d", c, level[3:0], e0);
      end
      checks++;
      if (level[7:4] !== e1[3:0]) begin
        errors++;
        $display("FAIL ramp_lvl1 c=%0d got %0d want %0d", c, level[7:4], e1);
      end
      checks++;
      if (pwm_out !== ep) begin
        errors++;
        $display("FAIL ramp_pwm c=%0d got %b want %b", c, pwm_out, ep);
      end
      checks++;
      if (wrap !== ew) begin
        errors++;
        $display("FAIL ramp_wrap c=%0d got %b want %b", c, wrap, ew);
      end
    end
  endtask

  task automatic test_pause();
    int e0, e1, eff, effp, highs;
    logic [1:0] ep;
    logic ew;
    highs = 0;
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      @(negedge clk);
      eff   = (c <= 13) ? c : ((c <= 23) ? 13 : c - 10);
      effp  = ((c - 1) <= 13) ? (c - 1) : (((c - 1) <= 23) ? 13 : c - 11);
      e0    = exp_lvl(eff / 4, 0);
      e1    = exp_lvl(eff / 4, 3);
      ep[0] = ((c - 1) % 8) < exp_lvl(effp / 4, 0);
      ep[1] = ((c - 1) % 8) < exp_lvl(effp / 4, 3);
      ew    = (c <= 13 || c >= 24) && (eff > 0) && (eff % 48 == 0);
      checks++;
      if (level[3:0] !== e0[3:0]) begin
        errors++;
        $display("FAIL pause_lvl0 c=%0d got %0d want %0d", c, level[3:0], e0);
      end
      checks++;
      if (level[7:4] !== e1[3:0]) begin
        errors++;
        $display("FAIL pause_lvl1 c=%0d got %0d want %0d", c, level[7:4], e1);
      end
      checks++;
      if (pwm_out !== ep) begin
        errors++;
        $display("FAIL pause_pwm c=%0d got %b want %b", c, pwm_out, ep);
      end
      checks++;
      if (wrap !== ew) begin
        errors++;
        $display("FAIL pause_wrap c=%0d got %b want %b", c, wrap, ew);
      end
      if (c >= 15 && c <= 22 && pwm_out[0] === 1'b1) highs++;
      if (c == 22) begin
        checks++;
        if (highs != 6) begin
          errors++;
          $display("FAIL duty_at_6 got %0d want 6", highs);
        end
      end
      if (c == 13) en = 1'b0;
      if (c == 23) en = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    int e0, e1;
    logic [1:0] ep;
    logic ew;
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk);
      @(negedge clk);
      e0 = exp_lvl(c / 4, 0);
      checks++;
      if (level[3:0] !== e0[3:0]) begin
        errors++;
        $display("FAIL mid_pre_lvl0 c=%0d got %0d want %0d", c, level[3:0], e0);
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL mid_rst_level got %h want 0", level);
    end
    checks++;
    if (pwm_out !== '0) begin
      errors++;
      $display("FAIL mid_rst_pwm got %b want 0", pwm_out);
    end
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      e0    = exp_lvl(c / 4, 0);
      e1    = exp_lvl(c / 4, 3);
      ep[0] = ((c - 1) % 8) < exp_lvl((c - 1) / 4, 0);
      ep[1] = ((c - 1) % 8) < exp_lvl((c - 1) / 4, 3);
      ew    = (c % 48 == 0);
      checks++;
      if (level[3:0] !== e0[3:0]) begin
        errors++;
        $display("FAIL mid_lvl0 c=%0d got %0d want %0d", c, level[3:0], e0);
      end
      checks++;
      if (level[7:4] !== e1[3:0]) begin
        errors++;
        $display("FAIL mid_lvl1 c=%0d got %0d want %0d", c, level[7:4], e1);
      end
      checks++;
      if (pwm_out !== ep) begin
        errors++;
        $display("FAIL mid_pwm c=%0d got %b want %b", c, pwm_out, ep);
      end
      checks++;
      if (wrap !== ew) begin
        errors++;
        $display("FAIL mid_wrap c=%0d got %b want %b", c, wrap, ew);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_ramp();
    test_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
